// File: rtl/assoc_search_pkg.sv
// Shared types and width helpers for the associative-memory search stage.
package assoc_search_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } search_state_e;

   localparam int unsigned HV_DIM_DEFAULT    = 512;
   localparam int unsigned NUM_CLASS_DEFAULT = 32;

   // Bits needed to hold any value 0..max_val.
   function automatic int unsigned count_width(input int unsigned max_val);
      return (max_val < 2) ? 1 : $clog2(max_val + 1);
   endfunction

   // Bits needed to address num_entries locations.
   function automatic int unsigned addr_width(input int unsigned num_entries);
      return (num_entries < 2) ? 1 : $clog2(num_entries);
   endfunction

endpackage

// File: rtl/hv_popcount.sv
// Combinational popcount built as a recursive balanced adder tree; output is
// wide enough for the full count of HVDimension bits.
module hv_popcount
   import assoc_search_pkg::*;
#(
   parameter int unsigned HVDimension = HV_DIM_DEFAULT,
   parameter int unsigned DistWidth   = count_width(HVDimension)
) (
   input  logic [HVDimension-1:0] data_i,
   output logic [DistWidth-1:0]   count_o
);

   if (HVDimension == 1) begin : g_leaf
      assign count_o = DistWidth'(data_i);
   end else begin : g_split
      localparam int unsigned LoW     = HVDimension / 2;
      localparam int unsigned HiW     = HVDimension - LoW;
      localparam int unsigned LoDistW = count_width(LoW);
      localparam int unsigned HiDistW = count_width(HiW);

      logic [LoDistW-1:0] lo_cnt;
      logic [HiDistW-1:0] hi_cnt;

      hv_popcount #(.HVDimension(LoW), .DistWidth(LoDistW)) u_lo (
         .data_i  (data_i[LoW-1:0]),
         .count_o (lo_cnt)
      );

      hv_popcount #(.HVDimension(HiW), .DistWidth(HiDistW)) u_hi (
         .data_i  (data_i[HVDimension-1:LoW]),
         .count_o (hi_cnt)
      );

      assign count_o = DistWidth'(lo_cnt) + DistWidth'(hi_cnt);
   end

endmodule

// File: rtl/assoc_mem_search.sv
// Nearest-class search: streams class HVs, tracks minimum Hamming distance.
// Optional macro ASSOC_SEARCH_PIPE_EN adds a register between popcount and compare.
//
// state | meaning
// IDLE  | waiting for start, start_ready_o high
// RUN   | issuing one class-memory read per cycle
// DRAIN | consuming the last read data (two cycles when pipelined)
// DONE  | result valid, waiting for result_ready_i
module assoc_mem_search
   import assoc_search_pkg::*;
#(
   parameter int unsigned HVDimension    = HV_DIM_DEFAULT,
   parameter int unsigned NumClass       = NUM_CLASS_DEFAULT,
   parameter int unsigned ClassAddrWidth = addr_width(NumClass),
   parameter int unsigned NumClassWidth  = count_width(NumClass),
   parameter int unsigned DistWidth      = count_width(HVDimension)
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic [HVDimension-1:0]    query_i,
   input  logic [NumClassWidth-1:0]  num_classes_i,
   input  logic                      start_valid_i,
   output logic                      start_ready_o,
   output logic                      am_rd_en_o,
   output logic [ClassAddrWidth-1:0] am_addr_o,
   input  logic [HVDimension-1:0]    am_rd_data_i,
   output logic [ClassAddrWidth-1:0] predict_o,
   output logic [DistWidth-1:0]      hamming_dist_o,
   output logic                      result_valid_o,
   input  logic                      result_ready_i,
   output logic                      busy_o
);

   localparam logic [NumClassWidth-1:0] NumClassVal = NumClassWidth'(NumClass);
   localparam logic [DistWidth-1:0]     MaxDist     = DistWidth'(HVDimension);

   search_state_e state_q, state_d;

   logic [HVDimension-1:0]    query_q, query_d;
   logic [ClassAddrWidth-1:0] addr_q, addr_d;
   logic [ClassAddrWidth-1:0] last_q, last_d;
   logic                      rd_vld_q;
   logic [ClassAddrWidth-1:0] rd_idx_q;
   logic [DistWidth-1:0]      best_dist_q, best_dist_d;
   logic [ClassAddrWidth-1:0] best_idx_q, best_idx_d;

   logic                      start_fire;
   logic [NumClassWidth-1:0]  num_clamped;
   logic [DistWidth-1:0]      cur_dist;
   logic                      cmp_vld;
   logic [DistWidth-1:0]      cmp_dist;
   logic [ClassAddrWidth-1:0] cmp_idx;
   logic                      drain_last;

   assign num_clamped = (num_classes_i > NumClassVal) ? NumClassVal : num_classes_i;

   hv_popcount #(.HVDimension(HVDimension), .DistWidth(DistWidth)) u_popcount (
      .data_i  (am_rd_data_i ^ query_q),
      .count_o (cur_dist)
   );

`ifdef ASSOC_SEARCH_PIPE_EN
   logic                      pipe_vld_q;
   logic [DistWidth-1:0]      pipe_dist_q;
   logic [ClassAddrWidth-1:0] pipe_idx_q;
   logic                      drain_cnt_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         pipe_vld_q  <= 1'b0;
         pipe_dist_q <= '0;
         pipe_idx_q  <= '0;
         drain_cnt_q <= 1'b0;
      end else begin
         pipe_vld_q  <= rd_vld_q;
         pipe_dist_q <= cur_dist;
         pipe_idx_q  <= rd_idx_q;
         drain_cnt_q <= (state_q == DRAIN) && !drain_cnt_q;
      end
   end

   assign cmp_vld    = pipe_vld_q;
   assign cmp_dist   = pipe_dist_q;
   assign cmp_idx    = pipe_idx_q;
   assign drain_last = drain_cnt_q;
`else
   assign cmp_vld    = rd_vld_q;
   assign cmp_dist   = cur_dist;
   assign cmp_idx    = rd_idx_q;
   assign drain_last = 1'b1;
`endif

   always_comb begin
      state_d        = state_q;
      start_ready_o  = 1'b0;
      start_fire     = 1'b0;
      am_rd_en_o     = 1'b0;
      am_addr_o      = '0;
      result_valid_o = 1'b0;
      busy_o         = 1'b0;
      unique case (state_q)
         IDLE: begin
            start_ready_o = 1'b1;
            if (start_valid_i) begin
               start_fire = 1'b1;
               state_d    = (num_clamped == '0) ? DONE : RUN;
            end
         end
         RUN: begin
            busy_o     = 1'b1;
            am_rd_en_o = 1'b1;
            am_addr_o  = addr_q;
            if (addr_q == last_q) state_d = DRAIN;
         end
         DRAIN: begin
            busy_o = 1'b1;
            if (drain_last) state_d = DONE;
         end
         DONE: begin
            busy_o         = 1'b1;
            result_valid_o = 1'b1;
            if (result_ready_i) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      query_d     = query_q;
      addr_d      = addr_q;
      last_d      = last_q;
      best_dist_d = best_dist_q;
      best_idx_d  = best_idx_q;
      if (start_fire) begin
         query_d     = query_i;
         addr_d      = '0;
         last_d      = ClassAddrWidth'(num_clamped - NumClassWidth'(1));
         best_dist_d = MaxDist;
         best_idx_d  = '0;
      end else begin
         // Counter parks on the last address so it can never wrap.
         if (am_rd_en_o && (addr_q != last_q)) addr_d = addr_q + ClassAddrWidth'(1);
         // Strict compare: on a tie the earlier (lower) index is kept.
         if (cmp_vld && (cmp_dist < best_dist_q)) begin
            best_dist_d = cmp_dist;
            best_idx_d  = cmp_idx;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= IDLE;
         query_q     <= '0;
         addr_q      <= '0;
         last_q      <= '0;
         rd_vld_q    <= 1'b0;
         rd_idx_q    <= '0;
         best_dist_q <= '0;
         best_idx_q  <= '0;
      end else begin
         state_q     <= state_d;
         query_q     <= query_d;
         addr_q      <= addr_d;
         last_q      <= last_d;
         rd_vld_q    <= am_rd_en_o;
         rd_idx_q    <= am_addr_o;
         best_dist_q <= best_dist_d;
         best_idx_q  <= best_idx_d;
      end
   end

   assign predict_o      = best_idx_q;
   assign hamming_dist_o = best_dist_q;

endmodule

// File: tb/tb_assoc_mem_search.sv
// Directed bench for assoc_mem_search: class memory model, latency, tie,
// clamp, result back-pressure and mid-search reset cases.
module tb_assoc_mem_search;

   localparam int HV = 512;
   localparam int NC = 32;
   localparam int AW = 5;
   localparam int NW = 6;
   localparam int DW = 10;
`ifdef ASSOC_SEARCH_PIPE_EN
   localparam int PIPE = 1;
`else
   localparam int PIPE = 0;
`endif

   logic          clk_i = 1'b0;
   logic          rst_i;
   logic [HV-1:0] query_i;
   logic [NW-1:0] num_classes_i;
   logic          start_valid_i;
   logic          start_ready_o;
   logic          am_rd_en_o;
   logic [AW-1:0] am_addr_o;
   logic [HV-1:0] am_rd_data_i;
   logic [AW-1:0] predict_o;
   logic [DW-1:0] hamming_dist_o;
   logic          result_valid_o;
   logic          result_ready_i;
   logic          busy_o;

   int n_checks = 0;
   int n_fail   = 0;

   logic [HV-1:0] class_mem [NC];
   logic [HV-1:0] query;
   int            rd_cnt = 0;
   int            addr_log [256];

   assoc_mem_search #(.HVDimension(HV), .NumClass(NC)) dut (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .query_i        (query_i),
      .num_classes_i  (num_classes_i),
      .start_valid_i  (start_valid_i),
      .start_ready_o  (start_ready_o),
      .am_rd_en_o     (am_rd_en_o),
      .am_addr_o      (am_addr_o),
      .am_rd_data_i   (am_rd_data_i),
      .predict_o      (predict_o),
      .hamming_dist_o (hamming_dist_o),
      .result_valid_o (result_valid_o),
      .result_ready_i (result_ready_i),
      .busy_o         (busy_o)
   );

   always #5 clk_i = ~clk_i;

   // Class memory: one-cycle read latency, zeros when not enabled.
   always @(posedge clk_i) begin
      am_rd_data_i <= am_rd_en_o ? class_mem[am_addr_o] : '0;
      if (am_rd_en_o) begin
         addr_log[rd_cnt] <= int'(am_addr_o);
         rd_cnt           <= rd_cnt + 1;
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic logic [HV-1:0] flip(input logic [HV-1:0] v, input int n);
      logic [HV-1:0] r;
      r = v;
      for (int i = 0; i < n; i++) r[(i * 7) % HV] = ~r[(i * 7) % HV];
      return r;
   endfunction

   task automatic do_search(input string tag, input int n, input int exp_pred, input int exp_dist);
      int base, lat, nn, exp_lat;
      bit ok;
      nn      = (n > NC) ? NC : n;
      exp_lat = (nn == 0) ? 1 : nn + 2 + PIPE;
      base    = rd_cnt;
      @(negedge clk_i);
      check({tag, "_start_ready"}, start_ready_o, 1);
      query_i       = query;
      num_classes_i = n[NW-1:0];
      start_valid_i = 1'b1;
      @(posedge clk_i);
      lat = 1;
      @(negedge clk_i);
      start_valid_i = 1'b0;
      while (!result_valid_o && lat < 200) begin
         @(posedge clk_i);
         lat++;
         @(negedge clk_i);
      end
      check({tag, "_latency"}, lat, exp_lat);
      check({tag, "_predict"}, predict_o, exp_pred);
      check({tag, "_dist"}, hamming_dist_o, exp_dist);
      check({tag, "_busy"}, busy_o, 1);
      check({tag, "_reads"}, rd_cnt - base, nn);
      ok = 1'b1;
      for (int i = 0; i < rd_cnt - base; i++) if (addr_log[base + i] != i) ok = 1'b0;
      check({tag, "_addr_seq"}, ok, 1);
   endtask

   task automatic release_result(input string tag, input int exp_pred, input int exp_dist);
      @(negedge clk_i);
      result_ready_i = 1'b1;
      @(posedge clk_i);
      @(negedge clk_i);
      result_ready_i = 1'b0;
      check({tag, "_valid_drop"}, result_valid_o, 0);
      check({tag, "_idle_ready"}, start_ready_o, 1);
      check({tag, "_idle_busy"}, busy_o, 0);
      check({tag, "_hold_predict"}, predict_o, exp_pred);
      check({tag, "_hold_dist"}, hamming_dist_o, exp_dist);
   endtask

   task automatic load_t1();
      class_mem[0] = flip(query, 10);
      class_mem[1] = flip(query, 3);
      class_mem[2] = flip(query, 50);
      class_mem[3] = flip(query, 7);
   endtask

   initial begin
      int guard;
      query          = {16{32'hA5C3_0F96}};
      for (int i = 0; i < NC; i++) class_mem[i] = ~query;
      rst_i          = 1'b1;
      query_i        = '0;
      num_classes_i  = '0;
      start_valid_i  = 1'b0;
      result_ready_i = 1'b0;
      repeat (3) @(posedge clk_i);
      @(negedge clk_i);
      rst_i = 1'b0;
      check("rst_start_ready", start_ready_o, 1);
      check("rst_result_valid", result_valid_o, 0);
      check("rst_busy", busy_o, 0);
      check("rst_rd_en", am_rd_en_o, 0);
      check("rst_predict", predict_o, 0);
      check("rst_dist", hamming_dist_o, 0);

      load_t1();
      do_search("basic4", 4, 1, 3);
      release_result("basic4", 1, 3);

      class_mem[0] = flip(query, 5);
      class_mem[1] = flip(query, 5);
      class_mem[2] = flip(query, 9);
      do_search("tie_first", 3, 0, 5);
      release_result("tie_first", 0, 5);

      class_mem[0] = flip(query, 9);
      class_mem[1] = flip(query, 4);
      class_mem[2] = flip(query, 4);
      do_search("tie_later", 3, 1, 4);
      release_result("tie_later", 1, 4);

      do_search("zero_n", 0, 0, HV);
      release_result("zero_n", 0, HV);

      for (int i = 0; i < NC; i++) class_mem[i] = flip(query, 100 + i);
      class_mem[NC-1] = query;
      do_search("clamp40", 40, NC - 1, 0);
      release_result("clamp40", NC - 1, 0);

      load_t1();
      do_search("hold", 4, 1, 3);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk_i);
         check("hold_valid", result_valid_o, 1);
         check("hold_predict", predict_o, 1);
         check("hold_dist", hamming_dist_o, 3);
         check("hold_no_read", am_rd_en_o, 0);
         num_classes_i = 6'd2;
         start_valid_i = 1'b1;
      end
      @(negedge clk_i);
      start_valid_i = 1'b0;
      check("hold_still_valid", result_valid_o, 1);
      release_result("hold", 1, 3);
      class_mem[0] = flip(query, 12);
      class_mem[1] = flip(query, 11);
      do_search("after_hold", 2, 1, 11);
      release_result("after_hold", 1, 11);

      load_t1();
      @(negedge clk_i);
      query_i       = query;
      num_classes_i = 6'd4;
      start_valid_i = 1'b1;
      @(posedge clk_i);
      @(negedge clk_i);
      start_valid_i = 1'b0;
      guard = 0;
      while (!(am_rd_en_o && am_addr_o == 5'd2) && guard < 20) begin
         @(negedge clk_i);
         guard++;
      end
      check("abort_reach_addr2", guard < 20, 1);
      rst_i = 1'b1;
      @(posedge clk_i);
      @(negedge clk_i);
      rst_i = 1'b0;
      check("abort_rd_en", am_rd_en_o, 0);
      check("abort_valid", result_valid_o, 0);
      check("abort_start_ready", start_ready_o, 1);
      check("abort_busy", busy_o, 0);
      check("abort_predict", predict_o, 0);
      check("abort_dist", hamming_dist_o, 0);
      repeat (3) begin
         @(negedge clk_i);
         check("abort_no_result", result_valid_o, 0);
      end
      class_mem[0] = flip(query, 20);
      class_mem[1] = flip(query, 6);
      do_search("after_abort", 2, 1, 6);
      release_result("after_abort", 1, 6);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
